fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side drain stage downstream of the synchronous FIFO.
//  - Issues read enables to the FIFO and captures the returned words.
//  - Re-presents the words to a downstream consumer on a valid/ready stream.
//  - Provides credit-based backpressure with no word loss, a flush, and 1 word/cycle sustained.
// PARAMETERS
//  DATA_WIDTH  8  width of FIFO word and stream data
//  BUF_DEPTH   4  output buffer entries; legal range 3..16; 3 is the minimum for full rate
// PORTS
//  i_Clk           in   1           rising-edge clock
//  i_Reset         in   1           synchronous, active-low reset
//  i_Enable        in   1           level; permits reads from the FIFO
//  i_Flush         in   1           pulse; discard buffered and in-flight words
//  i_Fifo_Empty    in   1           FIFO empty flag
//  i_Fifo_Rd_Data  in   DATA_WIDTH  FIFO read data
//  i_Fifo_Valid    in   1           FIFO read data valid; fixed 1 cycle after o_Fifo_Rd_En
//  o_Fifo_Rd_En    out  1           read request to the FIFO
//  o_Valid         out  1           stream data valid
//  o_Data          out  DATA_WIDTH  stream data
//  i_Ready         in   1           downstream accepts when o_Valid && i_Ready
//  o_Busy          out  1           state != IDLE
// BEHAVIOUR
//  Reset (i_Reset==0 at a clock edge)
//   - All outputs go to 0, and the state goes to IDLE.
//   - occ (buffer occupancy), inflight and the pointers go to 0.
//   - Reset has priority over every other input, including mid-flush and mid-burst.
//  FSM states: IDLE, STREAM, FLUSH
//   - IDLE -> STREAM: i_Enable==1 && i_Flush==0.
//   - STREAM -> FLUSH: i_Flush==1. i_Flush has priority over i_Enable.
//   - STREAM -> IDLE: i_Enable==0 && inflight==0 && occ==0. Data already buffered still drains.
//   - FLUSH -> IDLE: inflight==0. The minimum FLUSH stay is 1 cycle.
//  Read issue (combinational)
//   - o_Fifo_Rd_En = (state==STREAM) && i_Enable && !i_Fifo_Empty && (occ + inflight) < BUF_DEPTH.
//   - inflight <= o_Fifo_Rd_En, so it is 0 or 1.
//   - The credit check ignores a same-cycle pop. This is deliberate and conservative.
//  Capture
//   - When i_Fifo_Valid && inflight && state!=FLUSH, write i_Fifo_Rd_Data at wr_ptr.
//   - When i_Fifo_Valid && !inflight, ignore the data and do not write.
//   - The buffer never overflows, by construction. A write when occ==BUF_DEPTH is an assertion failure.
//  Stream
//   - o_Valid = (occ != 0). o_Data = buf[rd_ptr], combinational from registered storage.
//   - A pop happens when o_Valid && i_Ready.
//   - Once o_Valid is high, o_Valid and o_Data hold until the word is accepted (AXI-style rule).
//  Simultaneous capture and pop: occ is unchanged and both pointers advance.
//  Pointers wrap modulo BUF_DEPTH.
//   - If BUF_DEPTH is not a power of 2, wrap compares explicitly against BUF_DEPTH-1.
//   - occ is $clog2(BUF_DEPTH+1) bits wide.
//  Latency: FIFO non-empty in cycle N with the buffer empty -> o_Fifo_Rd_En in N, capture at edge N+1,
//   o_Valid in N+2.
//  Throughput: back-to-back reads with i_Ready held high give 1 word/cycle.
//  Flush
//   - On entering FLUSH, occ and both pointers clear on the same edge, so o_Valid==0 next cycle.
//   - A word in flight returns during FLUSH and is dropped.
//   - A flush pulse in IDLE or FLUSH is ignored.
// CONFIGURATION
//  FIFO_RD_STREAM_STATS_EN defined: adds two outputs, both zeroed by reset and not cleared by flush.
//   - o_Beat_Cnt [31:0] counts accepted stream beats and wraps.
//   - o_Stall_Cnt [31:0] counts cycles with o_Valid && !i_Ready and saturates at 32'hFFFF_FFFF.
//  FIFO_RD_STREAM_STATS_EN undefined: the two outputs and counters do not exist, and behaviour is
//   otherwise identical.
// STRUCTURE
//  fifo_pkg holds:
//   - typedef enum logic [1:0] {IDLE, STREAM, FLUSH} rd_state_t
//   - localparam STATS_W = 32
//  One sub-module, stream_buf: the circular buffer with ptrs, occ, push, pop and clear ports.
//  The FSM, credit logic and stats live in fifo_rd_stream.
//  The bench pairs this block with the FIFO via the existing fifo_if plus a stream-side interface.
// TESTING
//  1 Reset: drive i_Reset=0 for 2 cycles with all inputs active -> all outputs 0 and o_Busy 0;
//    release with i_Enable=1 -> o_Busy 1 next cycle.
//  2 Streaming: push 8'h11..8'h18 into the FIFO with i_Ready=1 -> o_Fifo_Rd_En on 8 consecutive
//    cycles; o_Data 11..18 in order on 8 consecutive valid cycles; first o_Valid 2 cycles after the
//    first rd_en.
//  3 Backpressure: 16 words queued, i_Ready=0 -> o_Fifo_Rd_En stops after exactly 4 reads; occ==4;
//    o_Data holds 8'h00.. first word; restore i_Ready -> all 16 words delivered, none lost or
//    duplicated; i_Fifo_Empty=1.
//  4 Flush mid-burst: with occ==3 and inflight==1, pulse i_Flush -> o_Valid 0 next cycle; the
//    returning word is dropped; IDLE after 1 cycle; re-enable -> next FIFO word appears first.
//  5 Wrap and toggle: 40 words with i_Ready toggling 1/0 each cycle -> in-order delivery across
//    pointer wrap; with STATS_EN, o_Beat_Cnt==40 and o_Stall_Cnt equals the count of valid&&!ready
//    cycles.
//  6 Disable drain: clear i_Enable with occ==2 -> no further rd_en; both words delivered;
//    o_Busy falls the cycle after occ reaches 0.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared types and constants for the FIFO read-side drain stage
package fifo_rd_stream_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} rd_state_t;
    localparam int STATS_W = 32;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus downstream valid/ready stream
interface fifo_rd_stream_if #(parameter int DATA_WIDTH = 8);
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    modport master (
        output fifo_rd_en, valid, data,
        input  fifo_empty, fifo_valid, fifo_rd_data, ready
    );
    modport slave (
        input  fifo_rd_en, valid, data,
        output fifo_empty, fifo_valid, fifo_rd_data, ready
    );
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: circular output buffer with occupancy count and synchronous clear
module fifo_rd_stream_buf #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUF_DEPTH  = 4,
    localparam int PW         = $clog2(BUF_DEPTH),
    localparam int OW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [OW-1:0]         occ
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    // explicit wrap so non-power-of-2 depths work
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && occ != '0;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            occ <= occ + OW'(do_push) - OW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && occ == OW'(BUF_DEPTH)));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream with credit backpressure and flush.
// Define FIFO_RD_STREAM_STATS_EN to add beat and stall counters.
module fifo_rd_stream import fifo_rd_stream_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic                 busy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STATS_W-1:0]   beat_cnt,
    output logic [STATS_W-1:0]   stall_cnt
`endif
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          inflight;
    logic [OW-1:0] occ;
    logic          clear;
    logic          push;
    logic          pop;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= bus.fifo_rd_en;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (enable && !flush) ? STREAM : IDLE;
            STREAM:  state_nxt = flush ? FLUSH : (!enable && !inflight && occ == '0) ? IDLE : STREAM;
            FLUSH:   state_nxt = inflight ? FLUSH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // credit check ignores a same-cycle pop on purpose
    always_comb begin
        bus.fifo_rd_en = state == STREAM && enable && !bus.fifo_empty
                         && (32'(occ) + 32'(inflight) < 32'(BUF_DEPTH));
        busy           = state != IDLE;
        clear          = state == STREAM && flush;
        push           = bus.fifo_valid && inflight && state != FLUSH;
        pop            = occ != '0 && bus.ready;
        bus.valid      = occ != '0;
    end
    fifo_rd_stream_buf #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) stream_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (bus.fifo_rd_data),
        .pop   (pop),
        .rdata (bus.data),
        .occ   (occ)
    );
`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt + STATS_W'(pop);
            if (bus.valid && !bus.ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule
